pc_fetch_unit: RTL

//  IF-stage program-counter owner: consumes the jump targets built in IF/ID ({PC+4[31:28], instr[25:0], 2'b00})
//  and branch targets from EX, and sequences the PC that addresses instruction memory.

---
 rtl/pc_fetch_unit_pkg.sv | 24 ++
 rtl/pc_redirect_arb.sv | 78 +++++++
 rtl/pc_fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the IF-stage program-counter unit.
// Holds the FSM state encoding, the redirect-source tags and the PC step/reset defaults.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_JUMP   = 2'd1,
        SRC_BRANCH = 2'd2
    } src_e;

    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: picks branch over jump and parks one redirect while the pipe is stalled.
// A live input redirect in the first unstalled cycle wins over the parked one, which is then discarded.
module pc_redirect_arb
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_i,
    input  logic                jump_valid_i,
    input  logic [PC_WIDTH-1:0] jump_target_i,
    input  logic                branch_valid_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic                redir_valid_o,
    output logic [PC_WIDTH-1:0] redir_target_o,
    output src_e                redir_src_o
);

    logic                pend_valid_q;
    src_e                pend_src_q;
    logic [PC_WIDTH-1:0] pend_target_q;
    logic                take_branch;
    logic                take_jump;

    // A jump never displaces a parked branch: the branch belongs to the older instruction.
    assign take_branch = stall_i && branch_valid_i;
    assign take_jump   = stall_i && jump_valid_i && !branch_valid_i &&
                         !(pend_valid_q && (pend_src_q == SRC_BRANCH));

    // NOTE: every output gets a default before the if-chain so no latch is inferred.
    always_comb begin
        redir_valid_o  = 1'b0;
        redir_target_o = branch_target_i;
        redir_src_o    = SRC_NONE;
        if (!stall_i) begin
            if (branch_valid_i) begin
                redir_valid_o  = 1'b1;
                redir_target_o = branch_target_i;
                redir_src_o    = SRC_BRANCH;
            end else if (jump_valid_i) begin
                redir_valid_o  = 1'b1;
                redir_target_o = jump_target_i;
                redir_src_o    = SRC_JUMP;
            end else if (pend_valid_q) begin
                redir_valid_o  = 1'b1;
                redir_target_o = pend_target_q;
                redir_src_o    = pend_src_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_src_q   <= SRC_NONE;
        end else if (!stall_i) begin
            pend_valid_q <= 1'b0;
            pend_src_q   <= SRC_NONE;
        end else if (take_branch) begin
            pend_valid_q <= 1'b1;
            pend_src_q   <= SRC_BRANCH;
        end else if (take_jump) begin
            pend_valid_q <= 1'b1;
            pend_src_q   <= SRC_JUMP;
        end
    end

    // NOTE: the parked target is plain datapath qualified by pend_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (take_branch) begin
            pend_target_q <= branch_target_i;
        end else if (take_jump) begin
            pend_target_q <= jump_target_i;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage PC owner: sequences the fetch PC through BOOT/RUN/REDIR and applies jump/branch redirects.
// Build macro DELAY_SLOT_EN: when defined, jumps keep their delay slot (no flush, no REDIR bubble).
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter int                  IMEM_AW  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inStall,
    input  logic                inJumpValid,
    input  logic [PC_WIDTH-1:0] inJumpTarget,
    input  logic                inBranchValid,
    input  logic [PC_WIDTH-1:0] inBranchTarget,
    output logic [PC_WIDTH-1:0] outPc,
    output logic [PC_WIDTH-1:0] outPostPc,
    output logic [IMEM_AW-1:0]  outImemAddr,
    output logic                outFetchValid,
    output logic                outFlushIFID,
    output logic                outMisaligned
);

`ifdef DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                misaligned_q;

    logic                redir_valid;
    logic [PC_WIDTH-1:0] redir_target;
    src_e                redir_src;
    logic [PC_WIDTH-1:0] post_pc;
    logic [PC_WIDTH-1:0] applied_target;
    logic                flush_now;

    pc_redirect_arb #(
        .PC_WIDTH (PC_WIDTH)
    ) u_arb (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (inStall),
        .jump_valid_i    (inJumpValid),
        .jump_target_i   (inJumpTarget),
        .branch_valid_i  (inBranchValid),
        .branch_target_i (inBranchTarget),
        .redir_valid_o   (redir_valid),
        .redir_target_o  (redir_target),
        .redir_src_o     (redir_src)
    );

    assign post_pc        = pc_q + PC_WIDTH'(PC_INC);
    assign applied_target = {redir_target[PC_WIDTH-1:2], 2'b00};
    // With a delay slot the instruction behind a jump is architecturally live, so only branches squash.
    assign flush_now      = redir_valid && !(DELAY_SLOT && (redir_src == SRC_JUMP));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            if (!inStall) begin
                if (redir_valid) begin
                    pc_q         <= applied_target;
                    misaligned_q <= is_misaligned(redir_target[1:0]);
                    state_q      <= flush_now ? ST_REDIR : ST_RUN;
                end else begin
                    case (state_q)
                        ST_BOOT:  state_q <= ST_RUN;
                        ST_RUN:   pc_q    <= post_pc;
                        ST_REDIR: begin
                            pc_q    <= post_pc;
                            state_q <= ST_RUN;
                        end
                        default:  state_q <= ST_BOOT;
                    endcase
                end
            end
        end
    end

    assign outPc         = pc_q;
    assign outPostPc     = post_pc;
    assign outImemAddr   = pc_q[IMEM_AW+1:2];
    assign outFlushIFID  = (state_q != ST_RUN) || flush_now;
    assign outFetchValid = (state_q == ST_RUN) && !inStall && !flush_now;
    assign outMisaligned = misaligned_q;

endmodule
